// File: rtl/serial_magnitude_comparator_pkg.sv
// ---------------------------------------------------------------------------
// comparator_pkg
//   Shared definitions for the serial magnitude comparator:
//     - FSM state encoding (IDLE / COMPARE)
//     - num_digits()  : number of DIGIT-wide slices in a WIDTH-bit operand
//     - index_width() : bit width needed to index those slices
// ---------------------------------------------------------------------------
package comparator_pkg;

  // FSM state encoding
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COMPARE = 1'b1;

  // Number of slices walked per comparison. A non-positive digit is
  // rejected at elaboration by the top; returning 1 here only keeps
  // the arithmetic well defined until that check fires.
  function automatic int num_digits(input int width, input int digit);
    if (digit > 0) begin
      return width / digit;
    end
    return 1;
  endfunction

  // Width of the slice index. A single-slice comparator still gets a
  // one-bit index so the register never collapses to zero width.
  function automatic int index_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end
    return 1;
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// ---------------------------------------------------------------------------
// serial_magnitude_comparator_if
//   Request / result bundle of the serial magnitude comparator.
//     start            : request to begin a comparison
//     signed_mode      : 1 = two's-complement compare, 0 = unsigned
//     a, b             : operands, WIDTH bits each
//     busy             : comparison in progress
//     done             : one-cycle completion pulse
//     a_equals_b       : registered result a == b
//     a_less_than_b    : registered result a <  b
//     a_greater_than_b : registered result a >  b
//   master = requester side, slave = comparator side.
// ---------------------------------------------------------------------------
interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 16
) ();

  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             a_equals_b;
  logic             a_less_than_b;
  logic             a_greater_than_b;

  modport master (
    output start,
    output signed_mode,
    output a,
    output b,
    input  busy,
    input  done,
    input  a_equals_b,
    input  a_less_than_b,
    input  a_greater_than_b
  );

  modport slave (
    input  start,
    input  signed_mode,
    input  a,
    input  b,
    output busy,
    output done,
    output a_equals_b,
    output a_less_than_b,
    output a_greater_than_b
  );

endinterface

// File: rtl/serial_magnitude_comparator_digit_compare.sv
// ---------------------------------------------------------------------------
// digit_compare
//   Purely combinational unsigned compare of one DIGIT-wide slice.
//     a, b : slice operands (DIGIT bits)
//     gt   : a > b
//     lt   : a < b
//   Equality is implied when neither gt nor lt is set.
// ---------------------------------------------------------------------------
module digit_compare #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             gt,
  output logic             lt
);

  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// serial_magnitude_comparator
//   Compares two WIDTH-bit operands DIGIT bits per cycle, most significant
//   slice first, and exits as soon as a slice differs.
//     clk : rising-edge clock for all state
//     rst : synchronous active-high reset (clears state and result flags)
//     bus : serial_magnitude_comparator_if slave modport
//           (start / signed_mode / a / b in; busy / done / flags out)
//   Latency from the accepting edge: i+1 cycles when slice i is the first
//   difference, NUM_DIGITS cycles when the operands are equal.
// ---------------------------------------------------------------------------
module serial_magnitude_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic                          clk,
  input logic                          rst,
  serial_magnitude_comparator_if.slave bus
);

  localparam int NUM_DIGITS = num_digits(WIDTH, DIGIT);
  localparam int IDX_W      = index_width(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("serial_magnitude_comparator: WIDTH must be a positive multiple of DIGIT");
  end

  logic [0:0]       state;
  logic [IDX_W-1:0] slice_idx;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic             cap_signed;

  logic             done_q;
  logic             eq_q;
  logic             lt_q;
  logic             gt_q;

  logic [WIDTH-1:0] adj_a;
  logic [WIDTH-1:0] adj_b;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [DIGIT-1:0] slice_a;
  logic [DIGIT-1:0] slice_b;
  logic             slice_gt;
  logic             slice_lt;

  // Flipping the sign bit maps two's-complement ordering onto unsigned
  // ordering. The sign bit only lives in the MSB slice, so the flip is
  // applied to the whole captured word and lower slices are unaffected.
  // The current slice is brought to the top by a left shift, which keeps
  // the selection a simple constant part-select.
  always_comb begin
    adj_a            = cap_a;
    adj_b            = cap_b;
    adj_a[WIDTH-1]   = cap_a[WIDTH-1] ^ cap_signed;
    adj_b[WIDTH-1]   = cap_b[WIDTH-1] ^ cap_signed;
    shift_a          = adj_a << (DIGIT * int'(slice_idx));
    shift_b          = adj_b << (DIGIT * int'(slice_idx));
    slice_a          = shift_a[WIDTH-1 -: DIGIT];
    slice_b          = shift_b[WIDTH-1 -: DIGIT];
  end

  digit_compare #(
    .DIGIT (DIGIT)
  ) u_digit_compare (
    .a  (slice_a),
    .b  (slice_b),
    .gt (slice_gt),
    .lt (slice_lt)
  );

  // Operands are only captured on acceptance in IDLE, so activity on the
  // bus while busy cannot disturb a comparison in flight. Result flags
  // are written only together with done, so the previous result stays
  // visible until the next comparison completes. Reset clears the flags
  // so that no stale result is reported after an abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      slice_idx <= '0;
      done_q    <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      gt_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            cap_a      <= bus.a;
            cap_b      <= bus.b;
            cap_signed <= bus.signed_mode;
            slice_idx  <= '0;
            state      <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          if (slice_gt || slice_lt) begin
            gt_q   <= slice_gt;
            lt_q   <= slice_lt;
            eq_q   <= 1'b0;
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end else if (slice_idx == LAST_IDX) begin
            gt_q   <= 1'b0;
            lt_q   <= 1'b0;
            eq_q   <= 1'b1;
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            slice_idx <= slice_idx + IDX_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy             = (state == ST_COMPARE);
  assign bus.done             = done_q;
  assign bus.a_equals_b       = eq_q;
  assign bus.a_less_than_b    = lt_q;
  assign bus.a_greater_than_b = gt_q;

endmodule

// File: doc/serial_magnitude_comparator.md
SERIAL_MAGNITUDE_COMPARATOR -- requirements
Module: serial_magnitude_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, bits compared per cycle; WIDTH SHALL be an integer multiple of DIGIT, and DIGIT >= 1.
REQ-003 SHALL have port clk, input, 1, single clock for all state; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1, request to begin a comparison.
REQ-006 SHALL have port signed_mode, input, 1, 1 = two's-complement compare, 0 = unsigned compare.
REQ-007 SHALL have port a, input, WIDTH, first operand.
REQ-008 SHALL have port b, input, WIDTH, second operand.
REQ-009 SHALL have port busy, output, 1, comparison in progress.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port a_equals_b, output, 1, registered result: a == b.
REQ-012 SHALL have port a_less_than_b, output, 1, registered result: a < b.
REQ-013 SHALL have port a_greater_than_b, output, 1, registered result: a > b.

Function
REQ-014 SHALL implement FSM states IDLE and COMPARE; busy = (state == COMPARE).
REQ-015 In IDLE, a rising edge with start=1 SHALL capture a, b and signed_mode, load slice index 0 (MSB slice), and enter COMPARE.
REQ-016 In COMPARE, each cycle SHALL compare one DIGIT-wide slice of the captured operands, MSB slice first, NUM_DIGITS = WIDTH/DIGIT slices in total.
REQ-017 When signed_mode=1, the top bit of both operands SHALL be inverted before the MSB-slice compare; lower slices SHALL be compared unsigned.
REQ-018 When slice i differs, the next edge SHALL register a_greater_than_b or a_less_than_b, pulse done, and return to IDLE (early exit); latency = i+1 cycles.
REQ-019 When the last slice is equal, the next edge SHALL register a_equals_b=1, pulse done, and return to IDLE; latency = NUM_DIGITS cycles.
REQ-020 After any completed comparison, exactly one of the three result flags SHALL be 1; the flags SHALL hold until the next done.
REQ-021 done SHALL be high for exactly one cycle per accepted start.
REQ-022 start while busy=1 SHALL be ignored; captured operands and mode SHALL be unaffected by changes on a, b or signed_mode while busy.
REQ-023 start=1 in the done cycle (busy=0) SHALL be accepted; the previous flags SHALL remain valid until the new done.
REQ-024 The slice index SHALL be wide enough for NUM_DIGITS and SHALL never wrap; reaching the last slice forces exit.

Reset
REQ-025 rst=1 SHALL set state=IDLE, busy=0, done=0 and all three result flags to 0 (no valid result) at the next edge; rst SHALL take priority over start.
REQ-026 rst during COMPARE SHALL abort the comparison without asserting done.

Structure
REQ-027 Package comparator_pkg SHALL hold the FSM state encoding and the NUM_DIGITS / index-width localparam functions.
REQ-028 SHALL instantiate one combinational sub-module, digit_compare (DIGIT-wide inputs; gt and lt outputs), for the per-slice compare.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-029 a=0x1234, b=0x1234, unsigned -> done 4 cycles after start; a_equals_b=1, other flags 0.
REQ-030 a=0x8000, b=0x7FFF -> unsigned: done after 1 cycle, a_greater_than_b=1; signed: done after 1 cycle, a_less_than_b=1.
REQ-031 a=0x12F4, b=0x1204, unsigned -> done after 3 cycles, a_greater_than_b=1; a and b changed and start pulsed while busy -> result unchanged, no extra done.
REQ-032 rst=1 on the 2nd COMPARE cycle of a=0x0001, b=0x0002 -> next cycle busy=0, done=0, all flags 0; no done pulse follows.
REQ-033 start held high continuously with new operands in each done cycle -> each comparison accepted back-to-back; flags update only on their done.
REQ-034 Random and exhaustive compare against a behavioural model at WIDTH=8 with DIGIT=1, 2 and 8, both modes -> flags match the model; latency matches REQ-018/REQ-019.
